// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock behind a
// start/in_ready and out_valid/out_ready handshake. Divide-by-zero completes at once.
module seq_restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state, state_next;
  logic [DIVISOR_W:0]    rem_part;
  logic [DIVIDEND_W-1:0] quo_part;
  logic [DIVISOR_W-1:0]  dsr;
  logic [CNT_W-1:0]      count;
  logic [DIVISOR_W:0]    rem_step;
  logic [DIVIDEND_W-1:0] quo_step;

  // One restoring iteration: shift the next dividend bit into the partial
  // remainder, then subtract the divisor when it fits.
  function automatic logic [DIVISOR_W+DIVIDEND_W:0] restore_step(
    input logic [DIVISOR_W:0]    r,
    input logic [DIVIDEND_W-1:0] q,
    input logic [DIVISOR_W-1:0]  d
  );
    logic [DIVISOR_W:0]    r_shift;
    logic [DIVIDEND_W-1:0] q_shift;
    r_shift = {r[DIVISOR_W-1:0], q[DIVIDEND_W-1]};
    q_shift = {q[DIVIDEND_W-2:0], 1'b0};
    if (r_shift >= {1'b0, d}) begin
      r_shift    = r_shift - {1'b0, d};
      q_shift[0] = 1'b1;
    end
    return {r_shift, q_shift};
  endfunction

  assign {rem_step, quo_step} = restore_step(rem_part, quo_part, dsr);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (divisor == '0) ? DONE : CALC;
      CALC:    if (count == LAST_ITER) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they carry no input path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_part    <= '0;
      quo_part    <= '0;
      dsr         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dsr   <= divisor;
            count <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              rem_part    <= '0;
              quo_part    <= dividend;
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          rem_part <= rem_step;
          quo_part <= quo_step;
          count    <= count + 1'b1;
          if (count == LAST_ITER) begin
            quotient  <= quo_step;
            remainder <= rem_step[DIVISOR_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed scenarios plus
// randomized operands with consumer stalls, checked against plain integer division.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst, start, out_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       in_ready, out_valid, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_restoring_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void ref_div(input int a, input int b,
                                  output logic [7:0] q, output logic [3:0] r, output logic z);
    if (b == 0) begin
      q = 8'd255; r = 4'd0; z = 1'b1;
    end else begin
      q = 8'(a / b); r = 4'(a % b); z = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for the result; lat counts edges after the accept edge.
  task automatic run_op(input int a, input int b, output int lat, output int acc);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    dividend = 8'(a);
    divisor  = 4'(b);
    start    = 1'b1;
    tick();
    acc   = cyc;
    start = 1'b0;
    lat   = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 8'd0 ||
        remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b q=%0d r=%0d dbz=%b, required 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_basic();
    int lat, acc;
    run_op(200, 7, lat, acc);
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL basic_latency: got %0d required 8", lat);
    end
    checks++;
    if (quotient !== 8'd28 || remainder !== 4'd4 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL basic_200_7: q=%0d r=%0d dbz=%b, required 28 4 0", quotient, remainder, div_by_zero);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int a_tab[3] = '{255, 3, 15};
    int b_tab[3] = '{1, 9, 15};
    int lat, acc, prev_acc;
    logic [7:0] eq; logic [3:0] er; logic ez;
    out_ready = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 3; i++) begin
      run_op(a_tab[i], b_tab[i], lat, acc);
      ref_div(a_tab[i], b_tab[i], eq, er, ez);
      checks++;
      if (quotient !== eq || remainder !== er || div_by_zero !== ez || lat !== 8) begin
        errors++;
        $display("FAIL b2b_%0d_%0d: q=%0d r=%0d dbz=%b lat=%0d, required %0d %0d %b 8",
                 a_tab[i], b_tab[i], quotient, remainder, div_by_zero, lat, eq, er, ez);
      end
      if (i > 0) begin
        checks++;
        if (acc - prev_acc !== 10) begin
          errors++;
          $display("FAIL b2b_interval: got %0d cycles required 10", acc - prev_acc);
        end
      end
      prev_acc = acc;
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_div_zero();
    int lat, acc;
    run_op(15, 0, lat, acc);
    checks++;
    if (lat > 1 || quotient !== 8'd255 || remainder !== 4'd0 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL div_zero: lat=%0d q=%0d r=%0d dbz=%b, required lat<=1 255 0 1",
               lat, quotient, remainder, div_by_zero);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int lat, acc;
    run_op(77, 5, lat, acc);
    // start is held high while stalled in DONE and on the release edge; it must be ignored
    dividend = 8'd9; divisor = 4'd2; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 8'd15 || remainder !== 4'd2) begin
        errors++;
        $display("FAIL stall_%0d: out_valid=%b in_ready=%b q=%0d r=%0d, required 1 0 15 2",
                 i, out_valid, in_ready, quotient, remainder);
      end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0; start = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 8'd15 || remainder !== 4'd2) begin
      errors++;
      $display("FAIL stall_release: out_valid=%b in_ready=%b q=%0d r=%0d, required 0 1 15 2",
               out_valid, in_ready, quotient, remainder);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    tick(); lat++;
    tick(); lat++;
    dividend = 8'd0; divisor = 4'd1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); lat++; end
    start = 1'b0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    checks++;
    if (lat !== 8 || quotient !== 8'd28 || remainder !== 4'd4 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: lat=%0d q=%0d r=%0d dbz=%b, required 8 28 4 0",
               lat, quotient, remainder, div_by_zero);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, acc;
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 8'd0 ||
        remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b q=%0d r=%0d dbz=%b, required 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    tick();
    run_op(100, 3, lat, acc);
    checks++;
    if (lat !== 8 || quotient !== 8'd33 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_100_3: lat=%0d q=%0d r=%0d dbz=%b, required 8 33 1 0",
               lat, quotient, remainder, div_by_zero);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_random();
    int a, b, lat, acc, stall;
    logic [7:0] eq; logic [3:0] er; logic ez;
    for (int n = 0; n < 3000; n++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 15));
      run_op(a, b, lat, acc);
      ref_div(a, b, eq, er, ez);
      checks++;
      if (quotient !== eq || remainder !== er || div_by_zero !== ez ||
          (b != 0 && lat != 8) || (b == 0 && lat > 1)) begin
        errors++;
        $display("FAIL random_%0d_%0d: q=%0d r=%0d dbz=%b lat=%0d, required %0d %0d %b",
                 a, b, quotient, remainder, div_by_zero, lat, eq, er, ez);
      end
      stall = int'($urandom_range(0, 3));
      for (int s = 0; s < stall; s++) tick();
      checks++;
      if (out_valid !== 1'b1 || quotient !== eq || remainder !== er) begin
        errors++;
        $display("FAIL random_hold: out_valid=%b q=%0d r=%0d, required 1 %0d %0d",
                 out_valid, quotient, remainder, eq, er);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    test_reset();
    @(negedge clk) rst = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_stall();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
